// File: rtl/st7735_pkg.sv
// Shared constants for the st7735 pixel-source scheduler: RGB565 colours,
// pattern indices, default panel size and the vertical-bar palette.
package st7735_pkg;

    localparam int DEF_WIDTH  = 160;
    localparam int DEF_HEIGHT = 128;

    typedef enum logic [1:0] {
        PAT_CHECKER = 2'd0,
        PAT_SOLID   = 2'd1,
        PAT_BARS    = 2'd2,
        PAT_GRAD    = 2'd3
    } pattern_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] bar);
        logic [15:0] c;
        c = RGB_BLACK;
        case (bar)
            3'd0: c = RGB_WHITE;
            3'd1: c = RGB_YELLOW;
            3'd2: c = RGB_CYAN;
            3'd3: c = RGB_GREEN;
            3'd4: c = RGB_MAGENTA;
            3'd5: c = RGB_RED;
            3'd6: c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/st7735_pattern_gen.sv
// Combinational pattern generator: maps (x_eff, y, pattern) to an RGB565 colour.
// The caller registers the result.
module st7735_pattern_gen
    import st7735_pkg::*;
#(
    parameter int CHECK_SHIFT = 3
) (
    input  logic [7:0]  x_eff,
    input  logic [6:0]  y,
    input  pattern_e    pattern_idx,
    output logic [15:0] color
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        color = RGB_BLACK;
        unique case (pattern_idx)
            PAT_CHECKER: color = (x_eff[CHECK_SHIFT] ^ y[CHECK_SHIFT]) ? RGB_GREEN : RGB_RED;
            PAT_SOLID:   color = RGB_BLUE;
            PAT_BARS:    color = bar_color(x_eff[7:5]);
            PAT_GRAD:    color = {x_eff[7:3], y[6:1], 5'd0};
        endcase
    end

endmodule

// File: rtl/st7735_pattern_sched.sv
// Pixel-source scheduler: frame detection from the scan position, tear-free pattern
// stepping (manual or dwell-based), registered colour. Optional macro: ST7735_SCROLL_EN.
module st7735_pattern_sched
    import st7735_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int HEIGHT       = DEF_HEIGHT,
    parameter int DWELL_FRAMES = 60,
    parameter int CHECK_SHIFT  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic        advance,
    input  logic        auto_en,
    output logic [15:0] color,
    output logic [1:0]  pattern_idx,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);

    logic [7:0]    x_prev_q, x_prev_d;
    logic [6:0]    y_prev_q, y_prev_d;
    logic          frame_start_q, frame_start_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    pattern_e      pattern_q, pattern_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          adv_pending_q, adv_pending_d;
    logic [15:0]   color_q, color_d;
    logic [15:0]   color_next;
    logic [7:0]    x_eff;
    logic          boundary;
    logic          hit;

`ifdef ST7735_SCROLL_EN
    logic [7:0] scroll_q, scroll_d;
    assign x_eff = x + scroll_q;
`else
    assign x_eff = x;
`endif

    // A boundary is the first cycle the scan sits at the origin.
    assign boundary = (x == 8'd0) && (y == 7'd0) && !((x_prev_q == 8'd0) && (y_prev_q == 7'd0));
    assign hit      = adv_pending_q | advance | (auto_en & (dwell_q == DWELL_LAST));

    st7735_pattern_gen #(
        .CHECK_SHIFT (CHECK_SHIFT)
    ) u_gen (
        .x_eff       (x_eff),
        .y           (y),
        .pattern_idx (pattern_q),
        .color       (color_next)
    );

    always_comb begin
        x_prev_d      = x;
        y_prev_d      = y;
        frame_start_d = boundary;
        frame_cnt_d   = frame_cnt_q;
        pattern_d     = pattern_q;
        dwell_d       = dwell_q;
        adv_pending_d = adv_pending_q | advance;
        color_d       = color_next;
`ifdef ST7735_SCROLL_EN
        scroll_d      = scroll_q;
`endif
        if (boundary) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef ST7735_SCROLL_EN
            scroll_d    = scroll_q + 8'd1;
`endif
            if (hit) begin
                pattern_d     = pattern_e'(pattern_q + 2'd1);
                dwell_d       = '0;
                adv_pending_d = 1'b0;
            end else if (auto_en) begin
                dwell_d = dwell_q + 1'b1;
            end else begin
                dwell_d = '0;
            end
        end
    end

    // NOTE: reset is tested inside the clocked block, so it is synchronous; state uses <= only.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_prev_q      <= 8'(WIDTH - 1);
            y_prev_q      <= 7'(HEIGHT - 1);
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            pattern_q     <= PAT_CHECKER;
            dwell_q       <= '0;
            adv_pending_q <= 1'b0;
            color_q       <= '0;
`ifdef ST7735_SCROLL_EN
            scroll_q      <= '0;
`endif
        end else begin
            x_prev_q      <= x_prev_d;
            y_prev_q      <= y_prev_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            pattern_q     <= pattern_d;
            dwell_q       <= dwell_d;
            adv_pending_q <= adv_pending_d;
            color_q       <= color_d;
`ifdef ST7735_SCROLL_EN
            scroll_q      <= scroll_d;
`endif
        end
    end

    assign color       = color_q;
    assign pattern_idx = pattern_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_st7735_pattern_sched.sv
// Scoreboard bench for st7735_pattern_sched: the driver pushes hand-computed
// expectations tagged with a cycle, a negedge monitor pops and compares them.
module tb_st7735_pattern_sched;

    typedef enum {K_COLOR, K_FS, K_PIDX, K_FCNT} chk_e;

    typedef struct {
        int unsigned at;
        chk_e        kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  x = 8'd5;
    logic [6:0]  y = 7'd5;
    logic        advance = 1'b0;
    logic        auto_en = 1'b0;
    logic [15:0] color;
    logic [1:0]  pattern_idx;
    logic        frame_start;
    logic [15:0] frame_cnt;

    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    exp_t        e;
    logic [15:0] act;

    st7735_pattern_sched #(
        .WIDTH        (160),
        .HEIGHT       (128),
        .DWELL_FRAMES (2),
        .CHECK_SHIFT  (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .advance     (advance),
        .auto_en     (auto_en),
        .color       (color),
        .pattern_idx (pattern_idx),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
        $fatal(1);
    end

    // Monitor: compares every expectation whose cycle has come.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            tests++;
            case (e.kind)
                K_COLOR: act = color;
                K_FS:    act = {15'd0, frame_start};
                K_PIDX:  act = {14'd0, pattern_idx};
                default: act = frame_cnt;
            endcase
            if (e.at < cyc) begin
                fails++;
                $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.name, e.at, cyc);
            end else if (act !== e.exp) begin
                fails++;
                $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, act, e.exp);
            end
        end
    end

    task automatic step(input int xv, input int yv, input logic adv, input logic ae, input logic rst);
        @(negedge clk);
        x       = 8'(xv);
        y       = 7'(yv);
        advance = adv;
        auto_en = ae;
        reset   = rst;
    endtask

    // Expectation for the outputs that follow the inputs of the last step.
    task automatic ex(input chk_e k, input logic [15:0] v, input string n);
        exp_t it;
        it.at   = cyc + 1;
        it.kind = k;
        it.exp  = v;
        it.name = n;
        sb.push_back(it);
    endtask

    task automatic boundary(input logic adv, input logic ae, input int pidx, input int fcnt);
        step(0, 0, adv, ae, 1'b0);
        ex(K_FS, 16'd1, "fs_at_boundary");
        ex(K_PIDX, 16'(pidx), "pidx_at_boundary");
        ex(K_FCNT, 16'(fcnt), "fcnt_at_boundary");
        step(1, 1, 1'b0, ae, 1'b0);
        ex(K_FS, 16'd0, "fs_after_boundary");
    endtask

    logic [15:0] bars [8];
    int          auto_pidx [8];

    initial begin
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        auto_pidx = '{1, 2, 2, 3, 3, 0, 0, 1};

        // Reset values.
        repeat (3) step(5, 5, 1'b0, 1'b0, 1'b1);
        ex(K_COLOR, 16'h0000, "reset_color");
        ex(K_PIDX, 16'd0, "reset_pidx");
        ex(K_FS, 16'd0, "reset_fs");
        ex(K_FCNT, 16'd0, "reset_fcnt");

        // Frame 0: full raster scan, one frame_start at the origin only.
        for (int yy = 0; yy < 128; yy++) begin
            for (int xx = 0; xx < 160; xx++) begin
                step(xx, yy, 1'b0, 1'b0, 1'b0);
                ex(K_FS, (xx == 0 && yy == 0) ? 16'd1 : 16'd0, "raster_fs");
                if (xx == 0 && yy == 0) begin
                    ex(K_FCNT, 16'd1, "raster_fcnt");
                    ex(K_PIDX, 16'd0, "raster_pidx");
                    ex(K_COLOR, 16'hF800, "checker_0_0");
                end
                if (xx == 8 && yy == 0) ex(K_COLOR, 16'h07E0, "checker_8_0");
                if (xx == 8 && yy == 8) ex(K_COLOR, 16'hF800, "checker_8_8");
                if (xx == 159 && yy == 127) ex(K_PIDX, 16'd0, "raster_end_pidx");
            end
        end

        // Frame 1: three advances collapse into one step at the next boundary.
        boundary(1'b0, 1'b0, 0, 2);
        step(20, 3, 1'b1, 1'b0, 1'b0); ex(K_PIDX, 16'd0, "adv1_pidx_hold");
        step(21, 3, 1'b0, 1'b0, 1'b0);
        step(22, 3, 1'b1, 1'b0, 1'b0); ex(K_PIDX, 16'd0, "adv2_pidx_hold");
        step(23, 3, 1'b1, 1'b0, 1'b0); ex(K_PIDX, 16'd0, "adv3_pidx_hold");
        step(24, 3, 1'b0, 1'b0, 1'b0);
        boundary(1'b0, 1'b0, 1, 3);
        step(5, 9, 1'b0, 1'b0, 1'b0);     ex(K_COLOR, 16'h001F, "solid_a");
        step(100, 50, 1'b0, 1'b0, 1'b0);  ex(K_COLOR, 16'h001F, "solid_b");
        step(159, 127, 1'b0, 1'b0, 1'b0); ex(K_COLOR, 16'h001F, "solid_c");

        // Vertical bars.
        step(30, 30, 1'b1, 1'b0, 1'b0);
        boundary(1'b0, 1'b0, 2, 4);
        for (int k = 0; k < 8; k++) begin
            step(32 * k + 8, 10, 1'b0, 1'b0, 1'b0);
            ex(K_COLOR, bars[k], "bars");
        end

        // Gradient, then manual wrap 3 -> 0.
        step(30, 30, 1'b1, 1'b0, 1'b0);
        boundary(1'b0, 1'b0, 3, 5);
        step(168, 85, 1'b0, 1'b0, 1'b0);  ex(K_COLOR, 16'hAD40, "grad_a");
        step(152, 127, 1'b0, 1'b0, 1'b0); ex(K_COLOR, 16'h9FE0, "grad_b");
        step(30, 30, 1'b1, 1'b0, 1'b0);
        boundary(1'b0, 1'b0, 0, 6);

        // Advance coincident with the boundary; held origin pulses once.
        step(0, 0, 1'b1, 1'b0, 1'b0);
        ex(K_FS, 16'd1, "hold_fs_first");
        ex(K_PIDX, 16'd1, "same_cycle_adv_pidx");
        ex(K_FCNT, 16'd7, "same_cycle_adv_fcnt");
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1'b0, 1'b0, 1'b0);
            ex(K_FS, 16'd0, "hold_fs_repeat");
            ex(K_FCNT, 16'd7, "hold_fcnt");
        end
        step(3, 3, 1'b0, 1'b0, 1'b0); ex(K_FS, 16'd0, "hold_release_fs");
        boundary(1'b0, 1'b0, 1, 8);

        // Auto advance with dwell of two frames, including the 3 -> 0 wrap.
        for (int i = 0; i < 8; i++) boundary(1'b0, 1'b1, auto_pidx[i], 9 + i);

        // auto_en dropped mid-dwell clears the dwell count.
        boundary(1'b0, 1'b1, 1, 17);
        boundary(1'b0, 1'b0, 1, 18);
        boundary(1'b0, 1'b1, 1, 19);
        boundary(1'b0, 1'b1, 2, 20);

        // Reset mid-frame with an advance pending.
        step(50, 50, 1'b1, 1'b0, 1'b0);
        step(50, 50, 1'b0, 1'b0, 1'b1);
        step(50, 50, 1'b0, 1'b0, 1'b1);
        ex(K_COLOR, 16'h0000, "midreset_color");
        ex(K_PIDX, 16'd0, "midreset_pidx");
        ex(K_FS, 16'd0, "midreset_fs");
        ex(K_FCNT, 16'd0, "midreset_fcnt");
        step(60, 60, 1'b0, 1'b0, 1'b0);
        ex(K_COLOR, 16'hF800, "post_reset_color");
        ex(K_FS, 16'd0, "post_reset_fs");
        boundary(1'b0, 1'b0, 0, 1);
        boundary(1'b0, 1'b0, 0, 2);

        // Eight frames after reset; origin colour reflects scroll when enabled.
        for (int i = 3; i < 8; i++) boundary(1'b0, 1'b0, 0, i);
        step(0, 0, 1'b0, 1'b0, 1'b0);
        ex(K_FS, 16'd1, "fs_frame8");
        ex(K_FCNT, 16'd8, "fcnt_frame8");
        step(0, 0, 1'b0, 1'b0, 1'b0);
`ifdef ST7735_SCROLL_EN
        ex(K_COLOR, 16'h07E0, "scroll_origin_color");
`else
        ex(K_COLOR, 16'hF800, "scroll_origin_color");
`endif

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations never compared", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/st7735_pattern_sched.md
Name: st7735_pattern_sched

Overview:
Pixel-source scheduler between the st7735 driver and the display. It takes the driver's scan coordinates (x, y) and returns an RGB565 color from one of four built-in patterns. It detects frame boundaries from the scan position, so pattern changes happen only between frames and never tear. Patterns advance on a manual pulse or automatically after a programmable dwell in frames.

Parameters:
WIDTH, 160, panel columns; the driver's x runs 0..WIDTH-1
HEIGHT, 128, panel rows; the driver's y runs 0..HEIGHT-1
DWELL_FRAMES, 60, frames per pattern in auto mode (>=1)
CHECK_SHIFT, 3, checker cell size is 2^CHECK_SHIFT pixels

Ports:
clk  in  1  system clock, same clock as the st7735 driver
reset  in  1  synchronous, active-high reset
x  in  8  current column from the driver
y  in  7  current row from the driver
advance  in  1  single-cycle request to move to the next pattern
auto_en  in  1  level; enables dwell-based auto advance
color  out  16  RGB565 pixel to the driver
pattern_idx  out  2  active pattern
frame_start  out  1  single-cycle pulse at each frame boundary
frame_cnt  out  16  frames since reset, wraps at 2^16

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset); all state is updated on the rising edge of clk.
- Reset values: pattern_idx=0, frame_start=0, frame_cnt=0, color=0, dwell_cnt=0, adv_pending=0. The prev_xy register resets to (WIDTH-1, HEIGHT-1).
- Frame detection:
  - frame_start is asserted (registered) the cycle after (x,y)==(0,0) while prev_xy!=(0,0).
  - prev_xy <= (x,y) every cycle.
  - Because of the reset value of prev_xy, the first (0,0) after reset produces a pulse.
  - A held (0,0) produces exactly one pulse.
- adv_pending: set by advance; cleared only at a boundary that consumes it. Multiple advances within one frame collapse into one step.
- Boundary update, evaluated on the cycle frame_start is generated. Let hit = adv_pending|advance|(auto_en & dwell_cnt==DWELL_FRAMES-1).
  - If hit: pattern_idx <= pattern_idx+1 (3 wraps to 0), dwell_cnt <= 0, adv_pending <= 0.
  - Else if auto_en: dwell_cnt <= dwell_cnt+1.
  - Else: dwell_cnt <= 0.
  - frame_cnt <= frame_cnt+1 on every boundary.
- advance arriving in the same cycle as boundary detection takes effect at that boundary.
- auto_en deasserted mid-dwell clears dwell_cnt at the next boundary.
- Color: registered, latency 1 clk from (x,y), using the pattern_idx in effect at that cycle. The driver holds x,y for a full 16-bit SPI transfer, so this latency is invisible.
  - 0 checkered: (x[CHECK_SHIFT]^y[CHECK_SHIFT]) ? 16'h07E0 : 16'hF800
  - 1 solid: 16'h001F
  - 2 vertical bars, selected by x[7:5]: {FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000}
  - 3 gradient: {x[7:3], y[6:1], 5'd0}
- Reset mid-frame returns every register to its reset value; the next (0,0) from the driver produces frame_start. Any pending advance is lost.
- Coordinates outside WIDTH/HEIGHT are not checked; the patterns are computed from the raw bits.

Optional Feature:
ST7735_SCROLL_EN
- Defined: an 8-bit scroll register (reset 0) increments on every frame_start, wrapping at 256. The patterns use x_eff = x + scroll, an 8-bit wrapping sum, in place of x, giving horizontal motion.
- Undefined: x_eff = x, no scroll register, and output is identical to the base spec.

Decomposition:
- Package st7735_pkg: RGB565 color constants, bar palette, pattern index constants (PAT_CHECKER, PAT_SOLID, PAT_BARS, PAT_GRAD), default WIDTH/HEIGHT.
- One combinational sub-module, st7735_pattern_gen: inputs (x_eff, y, pattern_idx), output the next color.
- The scheduler keeps all sequential state: frame detect, dwell, pending advance, scroll.

Test Plan:
- Reset, then raster scan 160x128 with auto_en=0: frame_start pulses once per frame; frame_cnt increments 1,2,3; pattern_idx stays 0; at x=8,y=0 color=07E0 and at x=8,y=8 color=F800, both one cycle after the coordinates.
- advance pulsed 3 times mid-frame 1: pattern_idx stays 0 until the boundary, then becomes 1 exactly (not 3); color=001F everywhere in frame 2.
- auto_en=1, DWELL_FRAMES=2: pattern_idx goes 0,0,1,1,2,2,3,3,0 across boundaries; the wrap from 3 to 0 is checked.
- advance in the same cycle that (x,y) reaches (0,0): step applied at that boundary; a held (0,0) for 5 cycles gives a single frame_start.
- reset asserted at pattern_idx=2, mid-frame, with adv_pending=1: all outputs return to reset values; the next (0,0) gives frame_start with pattern_idx=0.
- ST7735_SCROLL_EN, pattern 0: after 8 frames, color at (0,0) equals the color at (8,0) in frame 0; without the macro it is unchanged.
